instr_prefetch_queue: RTL

Instruction prefetch queue sitting between the instruction memory and the IF stage of the pipelined CPU. It runs ahead of the pipeline, fetching sequential word addresses over a req/ack memory port into a small FIFO of {pc, instruction} entries. The IF stage pops entries with a valid/ready handshake. A redirect from the EX/MEM stage (taken branch, J, JR) discards all queued and in-flight instructions and restarts fetching at the target.

---
 rtl/instr_prefetch_queue_pkg.sv | 11 +
 rtl/instr_prefetch_queue_if.sv | 28 ++
 rtl/instr_prefetch_queue_fifo.sv | 44 ++++
 rtl/instr_prefetch_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// pfq_pkg: shared types and default sizes for the instruction prefetch queue
package pfq_pkg;
    localparam int PFQ_DEPTH = 4;
    localparam int PFQ_AW = 7;
    localparam int PFQ_DW = 32;
    typedef enum logic [1:0] {IDLE, REQ, KILL} pfq_state_t;
    typedef struct packed {
        logic [PFQ_AW-1:0] pc;
        logic [PFQ_DW-1:0] instr;
    } pfq_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: memory fetch port, redirect input and IF-stage pop port
interface instr_prefetch_queue_if
    import pfq_pkg::*;
#(
    parameter int DEPTH = PFQ_DEPTH,
    parameter int AW = PFQ_AW,
    parameter int DW = PFQ_DW
);
    logic imem_req;
    logic [AW-1:0] imem_addr;
    logic imem_ack;
    logic [DW-1:0] imem_rdata;
    logic redirect;
    logic [AW-1:0] redirect_pc;
    logic instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic instr_ready;
    logic [$clog2(DEPTH):0] count;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, count,
        input imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input imem_req, imem_addr, instr_valid, instr, instr_pc, count,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// pfq_fifo: entry storage with wrap-bit pointers, occupancy count and synchronous clear
module pfq_fifo
    import pfq_pkg::*;
#(
    parameter int DEPTH = PFQ_DEPTH,
    parameter int W = PFQ_AW + PFQ_DW
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic clr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    assign rdata = mem_q[rptr_q[PW-1:0]];
    assign count = wptr_q - rptr_q;
    assign empty = wptr_q == rptr_q;
    // clear drops all entries but leaves storage intact so the stale head stays visible
    always_comb begin
        mem_d = mem_q;
        wptr_d = clr ? '0 : wptr_q + (PW+1)'(push);
        rptr_d = clr ? '0 : rptr_q + (PW+1)'(pop);
        if (push && !clr) mem_d[wptr_q[PW-1:0]] = wdata;
    end
    // storage and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: runs ahead of IF, fetching sequential words into a FIFO; redirect flushes.
// Optional macro PFQ_BYPASS_EN forwards an acked word straight to the IF stage when the queue is empty.
module instr_prefetch_queue
    import pfq_pkg::*;
#(
    parameter int DEPTH = PFQ_DEPTH,
    parameter int AW = PFQ_AW,
    parameter int DW = PFQ_DW
) (
    input logic clk,
    input logic rst,
    instr_prefetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    pfq_state_t state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d, kill_addr_q, kill_addr_d, addr;
    logic push, pop, clr, empty, byp, ack_ok;
    logic [CW-1:0] cnt;
    logic [CW:0] cnt_next;
    logic [AW+DW-1:0] head;
    pfq_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr),
        .wdata({fetch_pc_q, bus.imem_rdata}), .rdata(head), .count(cnt), .empty(empty)
    );
    assign ack_ok = state_q == REQ && bus.imem_ack && !bus.redirect;
`ifdef PFQ_BYPASS_EN
    assign byp = empty && ack_ok;
`else
    assign byp = 1'b0;
`endif
    assign addr = state_q == KILL ? kill_addr_q : fetch_pc_q;
    assign bus.imem_req = state_q != IDLE;
    assign bus.imem_addr = addr;
    assign bus.count = cnt;
    assign bus.instr_valid = byp || (!empty && !bus.redirect);
    assign bus.instr = byp ? bus.imem_rdata : head[DW-1:0];
    assign bus.instr_pc = byp ? addr : head[AW+DW-1:DW];
    assign pop = bus.instr_valid && bus.instr_ready && !byp;
    assign push = ack_ok && !(byp && bus.instr_ready);
    assign cnt_next = {1'b0, cnt} + (CW+1)'(push) - (CW+1)'(pop);
    // fetch sequencing: only request with room left, and retire a killed request before refetching
    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_addr_d = kill_addr_q;
        clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    clr = 1'b1;
                    fetch_pc_d = bus.redirect_pc;
                    state_d = REQ;
                end else if (cnt_next < DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    clr = 1'b1;
                    fetch_pc_d = bus.redirect_pc;
                    if (!bus.imem_ack) begin
                        kill_addr_d = fetch_pc_q;
                        state_d = KILL;
                    end
                end else if (bus.imem_ack) begin
                    fetch_pc_d = fetch_pc_q + AW'(1);
                    state_d = cnt_next < DEPTH_C ? REQ : IDLE;
                end
            end
            KILL: begin
                if (bus.redirect) begin
                    clr = 1'b1;
                    fetch_pc_d = bus.redirect_pc;
                end
                if (bus.imem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end
    // FSM and address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fetch_pc_q <= '0;
            kill_addr_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_addr_q <= kill_addr_d;
        end
    end
endmodule
